finder_scan: RTL and testbench



---
 rtl/qr_pkg.sv | 22 ++
 rtl/run_ratio_check.sv | 48 ++++
 rtl/finder_scan.sv | 230 +++++++++++++++++++++++
 tb/tb_finder_scan.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// Shared types and widths for the finder-pattern scanner.
package qr_pkg;

    localparam int ADDR_W  = 20;
    localparam int RUN_W   = 9;
    localparam int TOT_W   = 12;
    localparam int COORD_W = 9;
    localparam int RUN_MAX = (1 << RUN_W) - 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } scan_state_t;

    // Run length increment that sticks at the largest representable length.
    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] len);
        return (len == RUN_W'(RUN_MAX)) ? len : len + 1'b1;
    endfunction

endpackage

// File: rtl/run_ratio_check.sv
// Combinational 1:1:3:1:1 finder test over the five most recent runs.
// Index 0 is the oldest run, index 4 the newest.
module run_ratio_check
    import qr_pkg::*;
#(
    parameter int MIN_TOTAL = 14
) (
    input  logic [4:0][RUN_W-1:0] run_len,
    input  logic [4:0]            run_color,
    input  logic [2:0]            run_count,
    output logic                  pass,
    output logic [TOT_W-1:0]      total
);

    localparam int         CW            = 14;
    localparam logic [4:0] FINDER_COLORS = 5'b01010;
    localparam logic [CW-1:0] MIN_T      = CW'(MIN_TOTAL);

    logic [CW-1:0]        sum;
    logic signed [CW-1:0] sum_s;
    logic signed [CW-1:0] diff;
    logic signed [CW-1:0] mag;
    logic                 ratio_ok;

    // Each run r must satisfy |14r - w*T| < T (w = 6 for the centre, 2 otherwise),
    // i.e. r lies within half a module of its ideal share of T/7.
    always_comb begin
        sum      = '0;
        ratio_ok = 1'b1;
        diff     = '0;
        mag      = '0;
        for (int i = 0; i < 5; i++) begin
            sum = sum + CW'(run_len[i]);
        end
        sum_s = $signed(sum);
        for (int i = 0; i < 5; i++) begin
            diff = $signed(CW'(14) * CW'(run_len[i])) - sum_s * ((i == 2) ? 14'sd6 : 14'sd2);
            mag  = diff[CW-1] ? -diff : diff;
            if (mag >= sum_s) begin
                ratio_ok = 1'b0;
            end
        end
        total = sum[TOT_W-1:0];
        pass  = (run_count == 3'd5) && (run_color == FINDER_COLORS) &&
                (sum >= MIN_T) && ratio_ok;
    end

endmodule

// File: rtl/finder_scan.sv
// Raster scanner that run-length encodes each image row read from BRAM and
// reports every position where the last five runs form a finder pattern.
module finder_scan
    import qr_pkg::*;
#(
    parameter int WIDTH     = 480,
    parameter int HEIGHT    = 480,
    parameter int MIN_TOTAL = 14
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic               pixel_in,
    output logic [ADDR_W-1:0]  addr_out,
    output logic               rd_en_out,
    output logic               hit_valid_out,
    output logic [COORD_W-1:0] hit_x_out,
    output logic [COORD_W-1:0] hit_y_out,
    output logic [TOT_W-1:0]   hit_total_out,
    output logic [7:0]         hit_count_out,
    output logic               busy_out,
    output logic               done_out
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [COORD_W-1:0] LAST_COL  = COORD_W'(WIDTH - 1);

    scan_state_t state, state_next;

    logic [ADDR_W-1:0]  issue_addr;
    logic [COORD_W-1:0] issue_col, issue_row;
    logic [1:0]         drain_cnt;

    logic               s1_valid, s2_valid;
    logic [COORD_W-1:0] s1_col, s1_row, s2_col, s2_row;

    logic [RUN_W-1:0]   cur_len;
    logic               cur_color;
    logic [COORD_W-1:0] cur_start;

    logic [4:0][RUN_W-1:0]   sr_len;
    logic [4:0]              sr_color;
    logic [2:0][COORD_W-1:0] sr_start;
    logic [2:0]              sr_cnt;
    logic                    pushed;
    logic [COORD_W-1:0]      push_row;

    logic             s2_last, clear_sr, push_a, push_b;
    logic [RUN_W-1:0] a_len;
    logic             chk_pass;
    logic [TOT_W-1:0] chk_total;

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the state-decoded BRAM/status outputs.
    always_comb begin
        state_next = state;
        rd_en_out  = 1'b0;
        addr_out   = '0;
        busy_out   = 1'b0;
        done_out   = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) state_next = SCAN;
            end
            SCAN: begin
                rd_en_out = 1'b1;
                addr_out  = issue_addr;
                busy_out  = 1'b1;
                if (issue_addr == LAST_ADDR) state_next = DRAIN;
            end
            DRAIN: begin
                busy_out = 1'b1;
                if (drain_cnt == 2'd3) state_next = DONE;
            end
            DONE: begin
                done_out   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Raster address counters and the drain timer; idle at zero outside SCAN.
    always_ff @(posedge clk_in) begin
        if (rst_in || state != SCAN) begin
            issue_addr <= '0;
            issue_col  <= '0;
            issue_row  <= '0;
        end else begin
            issue_addr <= issue_addr + 1'b1;
            if (issue_col == LAST_COL) begin
                issue_col <= '0;
                issue_row <= issue_row + 1'b1;
            end else begin
                issue_col <= issue_col + 1'b1;
            end
        end
        if (rst_in || state != DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + 1'b1;
        end
    end

    // Two-stage coordinate pipeline matching the BRAM read latency.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            s2_col   <= '0;
            s2_row   <= '0;
        end else begin
            s1_valid <= (state == SCAN);
            s1_col   <= issue_col;
            s1_row   <= issue_row;
            s2_valid <= s1_valid;
            s2_col   <= s1_col;
            s2_row   <= s1_row;
        end
    end

    // Decide which runs close on this sample. A colour change on the last
    // column closes two runs at once; the trailing one-pixel run only matters
    // when it is dark, since a finder always ends on a dark run.
    always_comb begin
        s2_last  = (s2_col == LAST_COL);
        clear_sr = 1'b0;
        push_a   = 1'b0;
        push_b   = 1'b0;
        a_len    = cur_len;
        if (s2_valid) begin
            if (s2_col == '0) begin
                clear_sr = 1'b1;
            end else if (pixel_in == cur_color) begin
                if (s2_last) begin
                    push_a = 1'b1;
                    a_len  = run_inc(cur_len);
                end
            end else begin
                push_a = 1'b1;
                push_b = s2_last && !pixel_in;
            end
        end
    end

    // Current run tracking and the five-entry run history.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cur_len   <= '0;
            cur_color <= 1'b0;
            cur_start <= '0;
            sr_len    <= '0;
            sr_color  <= '0;
            sr_start  <= '0;
            sr_cnt    <= '0;
            pushed    <= 1'b0;
            push_row  <= '0;
        end else begin
            pushed <= push_a;
            if (s2_valid) begin
                if (s2_col == '0 || pixel_in != cur_color) begin
                    cur_len   <= RUN_W'(1);
                    cur_color <= pixel_in;
                    cur_start <= s2_col;
                end else begin
                    cur_len <= run_inc(cur_len);
                end
            end
            if (clear_sr) begin
                sr_cnt <= '0;
            end else if (push_b) begin
                sr_len   <= {RUN_W'(1), a_len, sr_len[4:2]};
                sr_color <= {1'b0, cur_color, sr_color[4:2]};
                sr_start <= {s2_col, cur_start, sr_start[2]};
                sr_cnt   <= (sr_cnt >= 3'd3) ? 3'd5 : sr_cnt + 3'd2;
            end else if (push_a) begin
                sr_len   <= {a_len, sr_len[4:1]};
                sr_color <= {cur_color, sr_color[4:1]};
                sr_start <= {cur_start, sr_start[2:1]};
                sr_cnt   <= (sr_cnt == 3'd5) ? 3'd5 : sr_cnt + 3'd1;
            end
            if (push_a) begin
                push_row <= s2_row;
            end
        end
    end

    run_ratio_check #(
        .MIN_TOTAL(MIN_TOTAL)
    ) u_check (
        .run_len  (sr_len),
        .run_color(sr_color),
        .run_count(sr_cnt),
        .pass     (chk_pass),
        .total    (chk_total)
    );

    // Register a hit the cycle after the history update; values hold between strobes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_valid_out <= 1'b0;
            hit_x_out     <= '0;
            hit_y_out     <= '0;
            hit_total_out <= '0;
            hit_count_out <= '0;
        end else begin
            hit_valid_out <= pushed && chk_pass;
            if (pushed && chk_pass) begin
                hit_x_out     <= sr_start[0] + COORD_W'(sr_len[2] >> 1);
                hit_y_out     <= push_row;
                hit_total_out <= chk_total;
                if (hit_count_out != 8'hFF) hit_count_out <= hit_count_out + 8'd1;
            end
            if (state == IDLE && start_in) begin
                hit_count_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_finder_scan.sv
// Self-checking bench for finder_scan with a run-list reference model.
module tb_finder_scan;

    localparam int W    = 64;
    localparam int H    = 2;
    localparam int MINT = 14;
    localparam int NPIX = W * H;

    typedef struct {
        int x;
        int y;
        int total;
        int cyc;
    } hit_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic        pixel;
    logic [19:0] addr;
    logic        rd_en;
    logic        hit_valid;
    logic [8:0]  hx;
    logic [8:0]  hy;
    logic [11:0] htot;
    logic [7:0]  hcnt;
    logic        busy;
    logic        done;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   img [0:NPIX-1];
    logic rd1;

    hit_t hits[$];
    hit_t exp_hits[$];
    int   scan_starts[$];
    int   scan_lens[$];
    int   done_cycles[$];
    bit   mon_en  = 1'b0;
    bit   prev_rd = 1'b0;
    int   exp_idx = 0;

    finder_scan #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .MIN_TOTAL(MINT)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .start_in     (start),
        .pixel_in     (pixel),
        .addr_out     (addr),
        .rd_en_out    (rd_en),
        .hit_valid_out(hit_valid),
        .hit_x_out    (hx),
        .hit_y_out    (hy),
        .hit_total_out(htot),
        .hit_count_out(hcnt),
        .busy_out     (busy),
        .done_out     (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to timestamp monitored events.
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model with two cycles of read latency.
    always @(posedge clk) begin
        rd1   <= rd_en ? img[addr[6:0]] : 1'b1;
        pixel <= rd1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge: raster address check and event capture.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_en) begin
                if (!prev_rd) scan_starts.push_back(cyc);
                checkOutput("addr_raster", 32'(addr), 32'(exp_idx));
                exp_idx++;
            end else begin
                if (prev_rd) scan_lens.push_back(exp_idx);
                checkOutput("addr_idle", 32'(addr), 32'd0);
                exp_idx = 0;
            end
            if (hit_valid) hits.push_back('{int'(hx), int'(hy), int'(htot), cyc});
            if (done) begin
                done_cycles.push_back(cyc);
                checkOutput("done_with_hit", 32'(hit_valid), 32'd0);
            end
            prev_rd = rd_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic void setSpan(input int r, input int c0, input int len, input bit color);
        for (int k = 0; k < len; k++) begin
            if (c0 + k < W) img[r * W + c0 + k] = color;
        end
    endfunction

    function automatic void clearImage();
        for (int i = 0; i < NPIX; i++) img[i] = 1'b1;
    endfunction

    // Reference: split each row into runs, slide a 5-run window, apply the ratio rules.
    function automatic void modelScan(input int s);
        int rl[$];
        int rc[$];
        int rs[$];
        int t, d, wgt, close_col;
        bit ok, p;
        for (int r = 0; r < H; r++) begin
            rl.delete();
            rc.delete();
            rs.delete();
            for (int c = 0; c < W; c++) begin
                p = img[r * W + c];
                if (c == 0) begin
                    rl.push_back(1); rc.push_back(int'(p)); rs.push_back(c);
                end else if (int'(p) != rc[rc.size() - 1]) begin
                    rl.push_back(1); rc.push_back(int'(p)); rs.push_back(c);
                end else begin
                    rl[rl.size() - 1] = rl[rl.size() - 1] + 1;
                end
            end
            for (int i = 4; i < rl.size(); i++) begin
                t  = 0;
                ok = 1'b1;
                for (int j = 0; j < 5; j++) t += rl[i - 4 + j];
                for (int j = 0; j < 5; j++) begin
                    if (rc[i - 4 + j] != (j % 2)) ok = 1'b0;
                    wgt = (j == 2) ? 6 : 2;
                    d   = 14 * rl[i - 4 + j] - wgt * t;
                    if (d < 0) d = -d;
                    if (d >= t) ok = 1'b0;
                end
                if (t < MINT) ok = 1'b0;
                if (ok) begin
                    close_col = rs[i] + rl[i];
                    if (close_col > W - 1) close_col = W - 1;
                    exp_hits.push_back('{rs[i - 2] + rl[i - 2] / 2, r, t,
                                         s + r * W + close_col + 4});
                end
            end
        end
    endfunction

    function automatic void clearRecords();
        hits.delete();
        exp_hits.delete();
        scan_starts.delete();
        scan_lens.delete();
        done_cycles.delete();
    endfunction

    task automatic checkHits(input string name);
        checkOutput({name, ":hit_num"}, 32'(hits.size()), 32'(exp_hits.size()));
        for (int i = 0; i < exp_hits.size() && i < hits.size(); i++) begin
            checkOutput({name, ":hit_x"},     32'(hits[i].x),     32'(exp_hits[i].x));
            checkOutput({name, ":hit_y"},     32'(hits[i].y),     32'(exp_hits[i].y));
            checkOutput({name, ":hit_total"}, 32'(hits[i].total), 32'(exp_hits[i].total));
            checkOutput({name, ":hit_cycle"}, 32'(hits[i].cyc),   32'(exp_hits[i].cyc));
        end
    endtask

    // One full scan of the current image with timing and result checks.
    task automatic applyStimulus(input string name);
        int s;
        int lim;
        int n;
        clearRecords();
        s = cyc + 1;
        modelScan(s);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput({name, ":busy"}, 32'(busy), 32'd1);
        lim = NPIX + 40;
        while (done_cycles.size() == 0 && lim > 0) begin
            tick();
            lim--;
        end
        n = (exp_hits.size() > 255) ? 255 : exp_hits.size();
        checkOutput({name, ":done_count"}, 32'(done_cycles.size()), 32'd1);
        checkOutput({name, ":done_cycle"}, 32'(qget(done_cycles, 0)), 32'(s + NPIX + 4));
        checkOutput({name, ":scan_start"}, 32'(qget(scan_starts, 0)), 32'(s));
        checkOutput({name, ":scan_len"},   32'(qget(scan_lens, 0)), 32'(NPIX));
        checkOutput({name, ":busy_after"}, 32'(busy), 32'd0);
        checkOutput({name, ":hit_count"},  32'(hcnt), 32'(n));
        if (exp_hits.size() > 0) begin
            checkOutput({name, ":hold_x"},     32'(hx),   32'(exp_hits[exp_hits.size() - 1].x));
            checkOutput({name, ":hold_total"}, 32'(htot), 32'(exp_hits[exp_hits.size() - 1].total));
        end
        checkHits(name);
    endtask

    function automatic void plantFinder(input int r, input int c0, input int k, input bit jitter);
        int c;
        int len;
        c = c0;
        for (int j = 0; j < 5; j++) begin
            len = ((j == 2) ? 3 * k : k) + (jitter ? int'($urandom_range(1, 0)) : 0);
            setSpan(r, c, len, (j % 2) == 1);
            c += len;
        end
    endfunction

    // Directed and randomized stimulus in one linear sequence.
    initial begin
        int s;
        int lim;
        int col;
        int len;
        bit color;

        clearImage();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checkOutput("rst:addr",      32'(addr),      32'd0);
        checkOutput("rst:rd_en",     32'(rd_en),     32'd0);
        checkOutput("rst:hit_valid", 32'(hit_valid), 32'd0);
        checkOutput("rst:hit_x",     32'(hx),        32'd0);
        checkOutput("rst:hit_y",     32'(hy),        32'd0);
        checkOutput("rst:hit_total", 32'(htot),      32'd0);
        checkOutput("rst:hit_count", 32'(hcnt),      32'd0);
        checkOutput("rst:busy",      32'(busy),      32'd0);
        checkOutput("rst:done",      32'(done),      32'd0);
        mon_en = 1'b1;
        tick();

        $display("[TB] basic finder 2-2-6-2-2");
        clearImage();
        setSpan(0, 4, 2, 1'b0); setSpan(0, 6, 2, 1'b1); setSpan(0, 8, 6, 1'b0);
        setSpan(0, 14, 2, 1'b1); setSpan(0, 16, 2, 1'b0);
        applyStimulus("basic");

        $display("[TB] scaled finder x3 from column 0");
        clearImage();
        plantFinder(0, 0, 6, 1'b0);
        applyStimulus("scaled");

        $display("[TB] equal runs rejected");
        clearImage();
        for (int j = 0; j < 5; j++) setSpan(0, 10 + 2 * j, 2, (j % 2) == 1);
        applyStimulus("equal");

        $display("[TB] finder closed by row flush");
        clearImage();
        plantFinder(1, W - 14, 2, 1'b0);
        applyStimulus("flush");

        $display("[TB] finder split across rows");
        clearImage();
        setSpan(0, W - 10, 2, 1'b0); setSpan(0, W - 8, 2, 1'b1); setSpan(0, W - 6, 6, 1'b0);
        setSpan(1, 0, 2, 1'b1); setSpan(1, 2, 2, 1'b0);
        applyStimulus("split");

        $display("[TB] reset mid-scan");
        clearImage();
        setSpan(0, 4, 2, 1'b0); setSpan(0, 6, 2, 1'b1); setSpan(0, 8, 6, 1'b0);
        setSpan(0, 14, 2, 1'b1); setSpan(0, 16, 2, 1'b0);
        clearRecords();
        s = cyc + 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        lim = NPIX + 40;
        while (cyc < s + W + 10 && lim > 0) begin
            tick();
            lim--;
        end
        checkOutput("midrst:addr_before", 32'(addr), 32'(W + 10));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst:busy",      32'(busy),      32'd0);
        checkOutput("midrst:rd_en",     32'(rd_en),     32'd0);
        checkOutput("midrst:addr",      32'(addr),      32'd0);
        checkOutput("midrst:hit_count", 32'(hcnt),      32'd0);
        checkOutput("midrst:hit_valid", 32'(hit_valid), 32'd0);
        checkOutput("midrst:hit_x",     32'(hx),        32'd0);
        repeat (10) tick();
        checkOutput("midrst:no_done", 32'(done_cycles.size()), 32'd0);
        applyStimulus("restart");

        $display("[TB] start held high");
        clearImage();
        plantFinder(0, 0, 6, 1'b0);
        clearRecords();
        s = cyc + 1;
        modelScan(s);
        modelScan(s + NPIX + 4 + 2);
        start = 1'b1;
        lim = 3 * NPIX;
        while (scan_starts.size() < 2 && lim > 0) begin
            tick();
            lim--;
        end
        start = 1'b0;
        lim = 2 * NPIX;
        while (done_cycles.size() < 2 && lim > 0) begin
            tick();
            lim--;
        end
        repeat (10) tick();
        checkOutput("held:first_start", 32'(qget(scan_starts, 0)), 32'(s));
        checkOutput("held:first_len",   32'(qget(scan_lens, 0)),   32'(NPIX));
        checkOutput("held:first_done",  32'(qget(done_cycles, 0)), 32'(s + NPIX + 4));
        checkOutput("held:rescan",      32'(qget(scan_starts, 1)), 32'(qget(done_cycles, 0) + 2));
        checkOutput("held:scan_count",  32'(scan_starts.size()),   32'd2);
        checkOutput("held:done_count",  32'(done_cycles.size()),   32'd2);
        checkHits("held");

        for (int it = 0; it < 6; it++) begin
            $display("[TB] random image %0d", it);
            for (int r = 0; r < H; r++) begin
                col   = 0;
                color = 1'($urandom_range(1, 0));
                while (col < W) begin
                    len = int'($urandom_range(7, 1));
                    setSpan(r, col, len, color);
                    col += len;
                    color = ~color;
                end
            end
            if ($urandom_range(3, 0) != 0) begin
                len = int'($urandom_range(3, 1));
                plantFinder(int'($urandom_range(H - 1, 0)),
                            int'($urandom_range(W - 7 * len - 5, 0)), len, 1'b1);
            end
            applyStimulus("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
